seq_det_ctrl: RTL and testbench
===============================

Name: seq_det_ctrl

Overview:
Programmable serial sequence-detection controller. It holds a configurable pattern (1..MAX_LEN bits), an overlap/non-overlap mode and a window length. It sequences a detection run over a valid-qualified serial bit stream, counts matches, and reports completion. It generalises the fixed overlapping-1010 Moore detector, and the detector blocks in this codebase are configured and run through it.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16)
LEN_W, 5, width of cfg_len; must hold MAX_LEN
WIN_W, 8, width of window bit counter
CNT_W, 8, width of match counter

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  reset, asynchronous, active-high
cfg_we  in  1  write config registers (honoured only in IDLE)
cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received
cfg_len  in  LEN_W  pattern length; legal 1..MAX_LEN
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
cfg_window  in  WIN_W  number of valid bits per run; 0 = unlimited
start  in  1  begin a run (honoured only in IDLE)
abort  in  1  terminate a run immediately
bit_valid  in  1  bit_in is valid this cycle
bit_in  in  1  serial data
busy  out  1  state == RUN
match_pulse  out  1  one-cycle pulse per detected match
match_count  out  CNT_W  matches in current/last run, saturating
overflow  out  1  sticky; match_count saturated this run
done  out  1  one-cycle pulse at window completion
cfg_err  out  1  one-cycle pulse when start is rejected for illegal cfg_len

Behaviour:
- Reset (async): state IDLE; all outputs 0.
- Reset config values: pattern low 4 bits = 1010 (others 0), len = 4, overlap = 1, window = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - cfg_we latches all cfg_* on the clock edge.
  - start with cfg_len in 1..MAX_LEN goes to RUN and clears match_count, overflow, history, bit counter and fill counter.
  - start with cfg_len = 0 or cfg_len > MAX_LEN stays in IDLE and pulses cfg_err next cycle.
  - start together with abort: abort wins, nothing happens.
- RUN:
  - cfg_we and start are ignored.
  - For each bit_valid, shift history: hist <= {hist[MAX_LEN-2:0], bit_in}. The fill counter increments, saturating at cfg_len.
  - Match is asserted when the fill (including this bit) ≥ cfg_len AND hist_new[cfg_len-1:0] == cfg_pattern[cfg_len-1:0].
  - On a match: match_pulse is asserted on the next cycle (latency 1), and match_count increments on the same edge.
  - At all-ones, match_count holds its value and overflow is set.
  - Overlap = 1: history and fill are retained after a match.
  - Overlap = 0: fill clears to 0 after a match, so the next match needs cfg_len fresh bits.
  - Window: when cfg_window ≠ 0 and the cfg_window-th valid bit is consumed, go to DONE. That bit is still evaluated; its match_pulse coincides with done.
  - abort: go to IDLE next cycle. The bit in the abort cycle is discarded. No done pulse. match_count and overflow are retained.
- DONE: one cycle with done = 1, then IDLE. Results persist until the next accepted start.
- bit_valid outside RUN is ignored.
- Reset mid-run: immediate return to reset state; no done.

Test Plan:
1. Defaults after reset, start, window = 0, bits 1,0,1,0,1,0,1,0 → match_pulse after bits 4, 6 and 8; match_count = 3; no done; then abort → IDLE, busy = 0, count stays 3.
2. Config len = 4, pattern 1010, overlap = 0, window = 8; same 8 bits → matches after bits 4 and 8; match_count = 2. done pulses once, in the same cycle as the second match_pulse; busy drops.
3. Pattern 11, len = 2, overlap = 1, window = 6, bits all 1 with bit_valid toggling every other cycle → 5 matches, done after the 6th valid bit, gaps produce no pulses.
4. start with cfg_len = 0, then with cfg_len = 9 (MAX_LEN = 8) → cfg_err pulses each time, busy stays 0. cfg_we during RUN → config unchanged, verified by the next run.
5. CNT_W = 2, pattern 1, len = 1, window = 0, five 1-bits → match_count = 3, overflow = 1. The next start clears both to 0.
6. Assert rst mid-run after 3 matches → all outputs 0 immediately, state IDLE, config back to 1010/4/overlap/0. start + abort same cycle in IDLE → no run.

Source files
------------

// File: rtl/seq_det_ctrl.sv
// Programmable serial sequence-detection controller: configurable pattern,
// overlap mode and window; counts matches over a valid-qualified bit stream.
module seq_det_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 5,
  parameter int WIN_W   = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [WIN_W-1:0]   cfg_window,
  input  logic               start,
  input  logic               abort,
  input  logic               bit_valid,
  input  logic               bit_in,
  output logic               busy,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_count,
  output logic               overflow,
  output logic               done,
  output logic               cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic               ovl_r;
  logic [WIN_W-1:0]   win_r;

  // History keeps only the older bits; the newest bit comes straight from bit_in.
  logic [MAX_LEN-2:0] hist_p0;
  logic [MAX_LEN-1:0] hist_new;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill, fill_inc, fill_sat;
  logic [WIN_W-1:0]   bitcnt, bitcnt_inc;
  logic               len_ok, start_go, take_bit, hit, win_end;

  always_comb begin
    len_ok     = (len_r != '0) && (len_r <= LEN_W'(MAX_LEN));
    start_go   = (state == IDLE) && start && !abort;
    take_bit   = (state == RUN) && bit_valid && !abort;
    hist_new   = {hist_p0, bit_in};
    len_mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_r));
    end
    fill_inc   = fill + LEN_W'(1);
    fill_sat   = (fill_inc >= len_r) ? len_r : fill_inc;
    hit        = take_bit && (fill_inc >= len_r) &&
                 (((hist_new ^ pat_r) & len_mask) == '0);
    bitcnt_inc = bitcnt + WIN_W'(1);
    win_end    = take_bit && (win_r != '0) && (bitcnt_inc == win_r);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start_go && len_ok) state_nxt = RUN;
      RUN: begin
        if (abort)        state_nxt = IDLE;
        else if (win_end) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Stage p0 -> p1: history shift, match count and registered match pulse.
  always_ff @(posedge clk) begin
    if (start_go && len_ok) hist_p0 <= '0;
    else if (take_bit)      hist_p0 <= hist_new[MAX_LEN-2:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_r       <= MAX_LEN'(4'b1010);
      len_r       <= LEN_W'(4);
      ovl_r       <= 1'b1;
      win_r       <= '0;
      fill        <= '0;
      bitcnt      <= '0;
      match_count <= '0;
      overflow    <= 1'b0;
      match_pulse <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      match_pulse <= hit;
      cfg_err     <= start_go && !len_ok;
      if ((state == IDLE) && cfg_we) begin
        pat_r <= cfg_pattern;
        len_r <= cfg_len;
        ovl_r <= cfg_overlap;
        win_r <= cfg_window;
      end
      if (start_go && len_ok) begin
        fill        <= '0;
        bitcnt      <= '0;
        match_count <= '0;
        overflow    <= 1'b0;
      end else if (take_bit) begin
        bitcnt <= bitcnt_inc;
        // Non-overlapping mode demands a full fresh pattern after each match.
        fill   <= (hit && !ovl_r) ? '0 : fill_sat;
        if (hit) begin
          if (&match_count) overflow    <= 1'b1;
          else              match_count <= match_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed testbench for seq_det_ctrl; a second instance with a 2-bit match
// counter exercises saturation.
module tb_seq_det_ctrl;

  logic       clk, rst;
  logic       cfg_we, cfg_overlap, start, abort, bit_valid, bit_in;
  logic [7:0] cfg_pattern, cfg_window;
  logic [4:0] cfg_len;
  logic       busy, match_pulse, overflow, done, cfg_err;
  logic [7:0] match_count;
  logic       s_busy, s_match_pulse, s_overflow, s_done, s_cfg_err;
  logic [1:0] s_match_count;

  int n_checks = 0;
  int n_fail   = 0;

  seq_det_ctrl #(.MAX_LEN(8), .LEN_W(5), .WIN_W(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_window(cfg_window),
    .start(start), .abort(abort), .bit_valid(bit_valid), .bit_in(bit_in),
    .busy(busy), .match_pulse(match_pulse), .match_count(match_count),
    .overflow(overflow), .done(done), .cfg_err(cfg_err)
  );

  seq_det_ctrl #(.MAX_LEN(8), .LEN_W(5), .WIN_W(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_window(cfg_window),
    .start(start), .abort(abort), .bit_valid(bit_valid), .bit_in(bit_in),
    .busy(s_busy), .match_pulse(s_match_pulse), .match_count(s_match_count),
    .overflow(s_overflow), .done(s_done), .cfg_err(s_cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [7:0] pat, input logic [4:0] len,
                           input logic ovl, input logic [7:0] win);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_window = win;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({busy, match_pulse, done, cfg_err, overflow} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b want=00000", {busy, match_pulse, done, cfg_err, overflow});
    end
    n_checks++;
    if (match_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_count got=%0d want=0", match_count);
    end
  endtask

  task automatic test_overlap_default();
    logic exp;
    do_start();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_busy got=%b want=1", busy);
    end
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1; bit_in = (i % 2 == 0);
      tick();
      exp = (i == 3 || i == 5 || i == 7);
      n_checks++;
      if (match_pulse !== exp || done !== 1'b0) begin
        n_fail++;
        $display("FAIL t1_bit%0d pulse/done got=%b%b want=%b0", i + 1, match_pulse, done, exp);
      end
    end
    bit_valid = 1'b0;
    n_checks++;
    if (match_count !== 8'd3) begin
      n_fail++;
      $display("FAIL t1_count got=%0d want=3", match_count);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || match_count !== 8'd3) begin
      n_fail++;
      $display("FAIL t1_abort busy=%b count=%0d want busy=0 count=3", busy, match_count);
    end
  endtask

  task automatic test_window_nonoverlap();
    logic exp;
    write_cfg(8'b1010, 5'd4, 1'b0, 8'd8);
    do_start();
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1; bit_in = (i % 2 == 0);
      tick();
      exp = (i == 3 || i == 7);
      n_checks++;
      if (match_pulse !== exp || done !== (i == 7)) begin
        n_fail++;
        $display("FAIL t2_bit%0d pulse/done got=%b%b want=%b%b", i + 1, match_pulse, done, exp, (i == 7));
      end
    end
    bit_valid = 1'b0;
    n_checks++;
    if (match_count !== 8'd2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t2_count count=%0d busy=%b want count=2 busy=0", match_count, busy);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t2_after_done done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_gapped_valid();
    write_cfg(8'b11, 5'd2, 1'b1, 8'd6);
    do_start();
    for (int k = 1; k <= 6; k++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      tick();
      n_checks++;
      if (match_pulse !== (k >= 2) || done !== (k == 6)) begin
        n_fail++;
        $display("FAIL t3_valid%0d pulse/done got=%b%b want=%b%b", k, match_pulse, done, (k >= 2), (k == 6));
      end
      bit_valid = 1'b0;
      if (k < 6) begin
        tick();
        n_checks++;
        if (match_pulse !== 1'b0 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL t3_gap%0d pulse/done got=%b%b want=00", k, match_pulse, done);
        end
      end
    end
    n_checks++;
    if (match_count !== 8'd5) begin
      n_fail++;
      $display("FAIL t3_count got=%0d want=5", match_count);
    end
    tick();
  endtask

  task automatic test_cfg_err();
    logic [4:0] bad [2] = '{5'd0, 5'd9};
    for (int j = 0; j < 2; j++) begin
      write_cfg(8'b1010, bad[j], 1'b1, 8'd0);
      do_start();
      n_checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL t4_err_len%0d cfg_err=%b busy=%b want 1 0", bad[j], cfg_err, busy);
      end
      tick();
      n_checks++;
      if (cfg_err !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL t4_err_pulse_len%0d cfg_err=%b busy=%b want 0 0", bad[j], cfg_err, busy);
      end
    end
    write_cfg(8'b1010, 5'd4, 1'b1, 8'd4);
    do_start();
    // Config writes while running must not take effect.
    cfg_pattern = 8'b11; cfg_len = 5'd2; cfg_window = 8'd0; cfg_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1; bit_in = (i % 2 == 0);
      tick();
      n_checks++;
      if (match_pulse !== (i == 3) || done !== (i == 3)) begin
        n_fail++;
        $display("FAIL t4_run_bit%0d pulse/done got=%b%b want=%b%b", i + 1, match_pulse, done, (i == 3), (i == 3));
      end
    end
    cfg_we = 1'b0; bit_valid = 1'b0;
    n_checks++;
    if (match_count !== 8'd1) begin
      n_fail++;
      $display("FAIL t4_count got=%0d want=1", match_count);
    end
    tick();
  endtask

  task automatic test_saturate();
    write_cfg(8'b1, 5'd1, 1'b1, 8'd0);
    do_start();
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    n_checks++;
    if (s_match_count !== 2'd3 || s_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_sat count=%0d ovf=%b want 3 1", s_match_count, s_overflow);
    end
    n_checks++;
    if (match_count !== 8'd5 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_wide count=%0d ovf=%b want 5 0", match_count, overflow);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    do_start();
    n_checks++;
    if (s_match_count !== 2'd0 || s_overflow !== 1'b0 || s_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_restart count=%0d ovf=%b busy=%b want 0 0 1", s_match_count, s_overflow, s_busy);
    end
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    n_checks++;
    if (match_count !== 8'd3 || match_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL t6_pre count=%0d pulse=%b want 3 1", match_count, match_pulse);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, match_pulse, done, cfg_err, overflow} !== 5'b0 || match_count !== 8'd0) begin
      n_fail++;
      $display("FAIL t6_async flags=%b count=%0d want 00000 0", {busy, match_pulse, done, cfg_err, overflow}, match_count);
    end
    tick();
    rst = 1'b0;
    do_start();
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1; bit_in = (i % 2 == 0);
      tick();
      n_checks++;
      if (match_pulse !== (i == 3 || i == 5 || i == 7) || done !== 1'b0) begin
        n_fail++;
        $display("FAIL t6_defcfg_bit%0d pulse/done got=%b%b want=%b0", i + 1, match_pulse, done, (i == 3 || i == 5 || i == 7));
      end
    end
    bit_valid = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || match_count !== 8'd3 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_start_abort busy=%b count=%0d err=%b want 0 3 0", busy, match_count, cfg_err);
    end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; cfg_window = '0; start = 1'b0; abort = 1'b0;
    bit_valid = 1'b0; bit_in = 1'b0;
    test_reset();
    test_overlap_default();
    test_window_nonoverlap();
    test_gapped_valid();
    test_cfg_err();
    test_saturate();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
